clk_switch_ctrl: RTL and testbench
==================================

# clk_switch_ctrl

Sequencing controller for the glitch-free two-source clock mux. It runs on an always-on clock and drives the mux `sel` line. It watches the mux's per-source gate-enable status through synchronizers and reports completion or timeout of each source switch to software or power-management logic. It is the requesting end of the mux select interface: the mux performs the glitch-free handover, and this block issues the change and confirms the old gate closed and the new gate opened.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop depth of each status synchronizer. Legal range ≥2.
- `TIMEOUT_W`, default 8: width of the per-phase timeout counter.
- `TIMEOUT`, default 200: cycles allowed per wait phase. Legal range 2 ≤ `TIMEOUT` ≤ 2^`TIMEOUT_W`−1.

Ports:
- `clk`  in  1  always-on controller clock. Rising edge.
- `rst_n`  in  1  reset, **asynchronous, active-low**.
- `req_vld`  in  1  switch request valid.
- `req_src`  in  1  requested source: 1 = clk1, 0 = clk2. Same encoding as the mux `sel`.
- `req_rdy`  out  1  request accepted when `req_vld & req_rdy` at a rising edge.
- `en1_st`  in  1  mux clk1 gate-enable status. Asynchronous to `clk`.
- `en2_st`  in  1  mux clk2 gate-enable status. Asynchronous to `clk`.
- `sel`  out  1  registered select to the mux.
- `cur_src`  out  1  last confirmed active source.
- `busy`  out  1  switch in progress.
- `done`  out  1  one-cycle pulse: switch confirmed.
- `err`  out  1  one-cycle pulse: phase timed out.

## Operation
- Each status input passes through its own `SYNC_STAGES`-deep flop chain, reset to 0. All decisions use the synchronized values `en1_s` and `en2_s`. `on(x)` means `en1_s` if x=1, `en2_s` if x=0.
- States: IDLE, WAIT_OFF, WAIT_ON. The FSM also holds a `tgt` register (target source, reset value 0).
- Reset values:
  - state = WAIT_ON, `tgt` = 0.
  - `sel` = 0, `cur_src` = 0, `busy` = 1, `req_rdy` = 0, `done` = 0, `err` = 0.
  - Timeout counter = 0.
  - Effect: after reset, the block confirms clk2 is gated on.
- `req_rdy` = (state == IDLE). `busy` = (state != IDLE). Both are combinational from the state.
- IDLE, request accepted, `req_src == cur_src`:
  - Stay in IDLE. `sel` unchanged. `done` = 1 next cycle.
- IDLE, request accepted, `req_src != cur_src`:
  - `sel <= req_src`, `tgt <= req_src`, counter cleared, go to WAIT_OFF.
- WAIT_OFF:
  - If `on(cur_src)` == 0, clear the counter and go to WAIT_ON.
  - Otherwise the counter increments.
- WAIT_ON:
  - If `on(tgt)` == 1, then `cur_src <= tgt`, `done` = 1, go to IDLE.
  - Otherwise the counter increments.
- Timeout: in WAIT_OFF or WAIT_ON, when counter == `TIMEOUT`−1 and the exit condition is false:
  - `err` = 1, go to IDLE.
  - `sel` keeps its new value. `cur_src` is unchanged. Counter cleared.
- Simultaneous exit condition and timeout in the same cycle: the exit wins, with no `err`.
- `en1_s` and `en2_s` both high is ignored. Only the checked signal matters in each phase.
- `req_vld` outside IDLE is ignored and is not queued.
- `done` and `err` are registered and never high together.
- The counter never wraps, because `TIMEOUT` ≤ 2^`TIMEOUT_W`−1.

## Timing
- Acceptance at edge E0. `sel` and `busy` change after E0.
- Switch latency with an ideal mux: E0 → WAIT_OFF, then exit one cycle after the old status synchronizes low. WAIT_ON exits one cycle after the new status synchronizes high.
- `done` is high for exactly the first cycle of the return to IDLE. `req_rdy` is high in that same cycle, so back-to-back requests are accepted.
- Same-source request: `done` is high in the cycle after E0, and `req_rdy` stays 1 throughout.
- Timeout: `err` is high `TIMEOUT` cycles after entering the stalled phase. IDLE follows in the same cycle.
- Reset mid-operation: all outputs and state take their reset values immediately, asynchronously. A pending switch is abandoned and `sel` returns to 0.

## Test plan
- Reset release with `en2_st` rising 10 cycles later → `busy` = 1 until `done` pulses once, `SYNC_STAGES`+1 cycles after the rise. Then `cur_src` = 0 and `req_rdy` = 1.
- From IDLE/clk2, `req_src`=1 with a mux model (clk1 = 3× clk, clk2 = 7× clk) → `sel`=1 the cycle after acceptance, `en2_s` falls before `en1_s` rises, one `done` pulse, `cur_src`=1, `err` never asserted.
- `req_src` equal to `cur_src` → `done` next cycle, `sel` unchanged, `busy` stays 0.
- clk1 stopped, request to clk1 → `err` pulses exactly 200 cycles after entering WAIT_ON (`TIMEOUT`=200), then IDLE, `sel`=1, `cur_src`=0.
- `req_vld` held high during WAIT_OFF/WAIT_ON with alternating `req_src` → ignored, exactly one switch completes.
- `rst_n` low mid-WAIT_ON for 1 cycle → `sel`=0, `busy`=1, `done`=`err`=0 immediately, and the boot confirmation sequence reruns.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Sequencing controller for the glitch-free two-source clock mux: drives sel,
// confirms the old gate closed and the new gate opened, and times out stalled phases.
module clk_switch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_vld,
  input  logic req_src,
  output logic req_rdy,
  input  logic en1_st,
  input  logic en2_st,
  output logic sel,
  output logic cur_src,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OFF = 2'd1,
    WAIT_ON  = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] en1_sync_q, en2_sync_q;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   tgt_q, tgt_d;
  logic                   sel_q, sel_d;
  logic                   cur_src_q, cur_src_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   en1_s, en2_s;
  logic                   old_on, new_on, cnt_last;

  assign en1_s    = en1_sync_q[SYNC_STAGES-1];
  assign en2_s    = en2_sync_q[SYNC_STAGES-1];
  assign old_on   = cur_src_q ? en1_s : en2_s;
  assign new_on   = tgt_q ? en1_s : en2_s;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Reset lands in WAIT_ON targeting clk2, so boot confirms clk2 is gated on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_ON;
      en1_sync_q <= '0;
      en2_sync_q <= '0;
      cnt_q      <= '0;
      tgt_q      <= 1'b0;
      sel_q      <= 1'b0;
      cur_src_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en1_sync_q <= {en1_sync_q[SYNC_STAGES-2:0], en1_st};
      en2_sync_q <= {en2_sync_q[SYNC_STAGES-2:0], en2_st};
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      sel_q      <= sel_d;
      cur_src_q  <= cur_src_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Exit conditions are tested before the timeout so a late exit still wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    sel_d     = sel_q;
    cur_src_d = cur_src_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (req_src == cur_src_q) begin
            done_d = 1'b1;
          end else begin
            sel_d   = req_src;
            tgt_d   = req_src;
            cnt_d   = '0;
            state_d = WAIT_OFF;
          end
        end
      end
      WAIT_OFF: begin
        if (!old_on) begin
          cnt_d   = '0;
          state_d = WAIT_ON;
        end else if (cnt_last) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      WAIT_ON: begin
        if (new_on) begin
          cnt_d     = '0;
          cur_src_d = tgt_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (cnt_last) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_rdy = (state_q == IDLE);
    busy    = (state_q != IDLE);
    sel     = sel_q;
    cur_src = cur_src_q;
    done    = done_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: a small gate-enable mux model plus manual status
// drive, with a scoreboard of expected done/err events.
module tb_clk_switch_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_W   = 8;
  localparam int TIMEOUT     = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_vld = 1'b0;
  logic req_src = 1'b0;
  logic en1_st, en2_st;
  logic req_rdy, sel, cur_src, busy, done, err;

  logic clk1m = 1'b0, clk2m = 1'b0;
  logic model_on = 1'b0, en1_man = 1'b0, en2_man = 1'b0;
  logic s1a = 1'b0, s1b = 1'b0, en1_m = 1'b0;
  logic s2a = 1'b0, s2b = 1'b0, en2_m = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic is_err;
    logic cur;
    logic sel;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  clk_switch_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_vld(req_vld),
    .req_src(req_src),
    .req_rdy(req_rdy),
    .en1_st (en1_st),
    .en2_st (en2_st),
    .sel    (sel),
    .cur_src(cur_src),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;
  always #15 clk1m = ~clk1m;
  always #35 clk2m = ~clk2m;

  // Each gate opens only once the other gate is seen closed in its own domain.
  always @(negedge clk1m) begin
    s1a   <= sel & ~en2_m;
    s1b   <= s1a;
    en1_m <= s1b;
  end
  always @(negedge clk2m) begin
    s2a   <= ~sel & ~en1_m;
    s2b   <= s2a;
    en2_m <= s2b;
  end

  assign en1_st = model_on ? en1_m : en1_man;
  assign en2_st = model_on ? en2_m : en2_man;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic c, input logic s);
    sb_q.push_back({is_err, c, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(input string tag, input int bound, output int n);
    n = 0;
    @(negedge clk);
    while (!(done || err) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, done | err, 1);
  endtask

  always @(negedge clk) begin
    if (done || err) begin
      chk("evt_excl", done & err, 0);
      if (sb_q.size() == 0) begin
        chk("evt_unexpected", {done, err}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_kind", err, mon_e.is_err);
        chk("sb_cur", cur_src, mon_e.cur);
        chk("sb_sel", sel, mon_e.sel);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    int t_fall;
    int t_rise;

    // Boot: reset, then clk2 status rises 10 cycles after release
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rdy", req_rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur", cur_src, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("boot_wait_busy", busy, 1);
    en2_man = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("boot_done", done, (k == SYNC_STAGES + 1));
      if (k <= SYNC_STAGES) chk("boot_busy", busy, 1);
    end
    @(negedge clk);
    chk("boot_rdy", req_rdy, 1);
    chk("boot_idle", busy, 0);
    chk("boot_cur", cur_src, 0);
    chk("boot_done_once", done, 0);

    // Switch clk2 -> clk1 through the mux model
    tick();
    n = 0;
    while (!en2_m && n < 300) begin
      tick();
      n++;
    end
    chk("model_ready", en2_m, 1);
    model_on = 1'b1;
    req_vld  = 1'b1;
    req_src  = 1'b1;
    push_exp(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 req_vld = 1'b0;
    @(negedge clk);
    chk("sw_sel", sel, 1);
    chk("sw_busy", busy, 1);
    chk("sw_rdy", req_rdy, 0);
    t_fall = -1;
    t_rise = -1;
    cyc = 0;
    while (!(done || err) && cyc < 400) begin
      if (t_fall < 0 && !dut.en2_s) t_fall = cyc;
      if (t_rise < 0 && dut.en1_s) t_rise = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("sw_seen", done, 1);
    chk("sw_no_err", err, 0);
    chk("sw_order", (t_fall >= 0) && (t_rise > t_fall), 1);
    @(negedge clk);
    chk("sw_cur", cur_src, 1);
    chk("sw_idle", busy, 0);
    chk("sw_sel_hold", sel, 1);

    // Same-source request completes in one cycle without leaving IDLE
    tick();
    req_vld = 1'b1;
    req_src = 1'b1;
    push_exp(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 req_vld = 1'b0;
    @(negedge clk);
    chk("same_done", done, 1);
    chk("same_sel", sel, 1);
    chk("same_busy", busy, 0);
    chk("same_rdy", req_rdy, 1);

    // Back to clk2 so the timeout case starts from cur_src = 0
    tick();
    req_vld = 1'b1;
    req_src = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 req_vld = 1'b0;
    wait_evt("back", 400, n);
    @(negedge clk);
    chk("back_cur", cur_src, 0);

    // Timeout: clk1 never opens after clk2 closes
    en1_man  = 1'b0;
    en2_man  = 1'b1;
    model_on = 1'b0;
    tick();
    req_vld = 1'b1;
    req_src = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 req_vld = 1'b0;
    en2_man = 1'b0;
    for (int k = 1; k <= SYNC_STAGES + TIMEOUT; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("tmo_early", err, 0);
    end
    chk("tmo_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_done", done, 0);
    chk("tmo_rdy", req_rdy, 1);
    chk("tmo_sel", sel, 1);
    chk("tmo_cur", cur_src, 0);
    @(negedge clk);
    chk("tmo_pulse", err, 0);

    // Requests held valid with alternating source during a switch are ignored
    tick();
    req_vld = 1'b1;
    req_src = 1'b1;
    push_exp(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 req_src = ~req_src;
      @(negedge clk);
      chk("ign_sel", sel, 1);
      chk("ign_busy", busy, 1);
    end
    en1_man = 1'b1;
    @(posedge clk);
    #1 req_src = ~req_src;
    @(posedge clk);
    #1 req_vld = 1'b0;
    wait_evt("ign", 50, n);
    @(negedge clk);
    chk("ign_cur", cur_src, 1);
    repeat (5) @(negedge clk);
    chk("ign_idle", busy, 0);

    // Reset asserted while waiting in WAIT_ON, then boot reruns
    tick();
    req_vld = 1'b1;
    req_src = 1'b0;
    @(posedge clk);
    #1 req_vld = 1'b0;
    en1_man = 1'b0;
    repeat (SYNC_STAGES + 4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_sel", sel, 0);
    chk("rst2_busy", busy, 1);
    chk("rst2_done", done, 0);
    chk("rst2_err", err, 0);
    chk("rst2_rdy", req_rdy, 0);
    chk("rst2_cur", cur_src, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("reboot_busy", busy, 1);
    en2_man = 1'b1;
    wait_evt("reboot", 20, n);
    chk("reboot_lat", n, SYNC_STAGES + 1);
    @(negedge clk);
    chk("reboot_rdy", req_rdy, 1);
    chk("reboot_cur", cur_src, 0);
    chk("reboot_sel", sel, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
